pr2_id_ex_reg: RTL and testbench
================================

Name: pr2_id_ex_reg

Overview:
ID/EX pipeline register (PR2) for the 5-stage core, with integrated load-use hazard detection.
- Captures decoded instruction fields and register-file read data each cycle.
- Drives the PR2_* fields consumed by the EX stage and the forwarding unit.
- Inserts one bubble when a load in PR2 feeds the instruction in ID, because a load in PR3 cannot be forwarded.
- Handles branch flush and global hold; keeps a saturating load-use stall counter.

Parameters:
DATA_W, 16, width of register data and immediate
ALU_OP_W, 3, width of ALU operation code
CNT_W, 16, width of stall performance counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
hold  in  1  freeze PR2 contents and counter (memory wait)
flush  in  1  branch taken in EX; kill instruction entering PR2
ID_valid  in  1  ID holds a real instruction
ID_rs, ID_rt, ID_rd  in  3 each  register addresses
ID_uses_rs, ID_uses_rt  in  1 each  instruction actually reads rs / rt
ID_RF_write_en, ID_MEM_read, ID_MEM_write, ID_alu_src  in  1 each  control bits
ID_alu_op  in  ALU_OP_W  ALU operation
ID_imm, ID_rs_data, ID_rt_data  in  DATA_W each  immediate and RF read data
stall  out  1  hold PC and IF/ID this cycle (combinational)
PR2_valid, PR2_RF_write_en, PR2_MEM_read, PR2_MEM_write, PR2_alu_src  out  1 each  registered control bits
PR2_rs, PR2_rt, PR2_rd  out  3 each  registered addresses
PR2_alu_op  out  ALU_OP_W  registered ALU operation
PR2_imm, PR2_rs_data, PR2_rt_data  out  DATA_W each  registered data
stall_count  out  CNT_W  number of load-use bubbles inserted, saturating

Behaviour:
- Reset: all PR2_* outputs are 0, giving a bubble (PR2_valid=0, all enables 0). stall_count is 0.
- load_use = PR2_valid & PR2_MEM_read & PR2_RF_write_en & ID_valid & ((ID_uses_rs & PR2_rd==ID_rs) | (ID_uses_rt & PR2_rd==ID_rt)).
- stall = load_use & ~flush & ~rst. It is purely combinational from PR2 state and ID inputs, with no latency.
- Register update priority, evaluated each rising edge (highest first):
  1. rst: bubble; counter cleared.
  2. flush: bubble, regardless of hold or load_use. Counter unchanged.
  3. hold: all PR2_* and stall_count keep their values. The stall output is still computed.
  4. load_use: bubble; stall_count increments by 1, saturating at all-ones.
  5. Otherwise: every PR2_* field loads its ID_* counterpart, and PR2_valid = ID_valid.
- Bubble definition: all PR2_* fields are 0.
- Latency: ID fields appear on PR2_* one cycle after the capturing edge.
- Load-use stalls exactly one cycle. On the next cycle the load is in PR3 and a bubble is in PR2, so stall drops. The consumer then enters PR2 while the load is in PR4, where forwarding from PR4 applies.
- A load with PR2_RF_write_en=0 never stalls. Neither does ID_valid=0 or a match only on an unused operand (uses_*=0).
- Load to reg 0 follows the same rule as any other register; there is no special zero register.
- A load matching both rs and rt gives one stall and one counter increment.
- flush and load_use in the same cycle: stall=0, PR2 becomes a bubble, counter is not incremented.
- hold and load_use in the same cycle: stall=1, PR2 is frozen, counter is unchanged. The bubble is inserted on the first non-hold edge if load_use is still true then.
- rst mid-stall: the next cycle has a bubble in PR2 and stall=0.

Test Plan:
- Reset: assert rst 2 cycles with ID_valid=1 and random fields -> all PR2_* =0, stall=0, stall_count=0 after the edge.
- Normal flow: ID ADD rs=1 rt=2 rd=3 with rs_data=0x1234 -> the next cycle shows PR2_rs=1, PR2_rt=2, PR2_rd=3, PR2_rs_data=0x1234, PR2_valid=1, and stall stays 0 throughout.
- Load-use: LW rd=5 in PR2, ID instruction uses rs=5 -> stall=1 for exactly one cycle, PR2 bubble, stall_count=1. The consumer appears in PR2 on the following edge.
- Unused operand / non-load: LW rd=5 in PR2 with ID_uses_rt=0 and rt=5 -> stall=0. ADD rd=5 in PR2 with ID rs=5 -> stall=0.
- Flush priority: load_use condition and flush=1 in the same cycle -> stall=0, PR2_valid=0, stall_count unchanged. Same with hold=1 -> still a bubble.
- Hold and saturation: hold=1 for 3 cycles -> PR2 stays constant. With CNT_W=2, 5 load-use events -> stall_count reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/pr2_id_ex_reg.sv
// ID/EX pipeline register (PR2) with load-use hazard detection.
// Captures the decoded instruction from ID every cycle. A bubble is inserted
// when the load sitting in PR2 produces a register that the instruction in ID
// reads, because a load result in PR3 is not yet available for forwarding.
// The stall output tells the front end (PC, IF/ID) to hold for that cycle.
module pr2_id_ex_reg #(
  parameter int DATA_W   = 16,
  parameter int ALU_OP_W = 3,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hold,
  input  logic                flush,
  input  logic                ID_valid,
  input  logic [2:0]          ID_rs,
  input  logic [2:0]          ID_rt,
  input  logic [2:0]          ID_rd,
  input  logic                ID_uses_rs,
  input  logic                ID_uses_rt,
  input  logic                ID_RF_write_en,
  input  logic                ID_MEM_read,
  input  logic                ID_MEM_write,
  input  logic                ID_alu_src,
  input  logic [ALU_OP_W-1:0] ID_alu_op,
  input  logic [DATA_W-1:0]   ID_imm,
  input  logic [DATA_W-1:0]   ID_rs_data,
  input  logic [DATA_W-1:0]   ID_rt_data,
  output logic                stall,
  output logic                PR2_valid,
  output logic                PR2_RF_write_en,
  output logic                PR2_MEM_read,
  output logic                PR2_MEM_write,
  output logic                PR2_alu_src,
  output logic [2:0]          PR2_rs,
  output logic [2:0]          PR2_rt,
  output logic [2:0]          PR2_rd,
  output logic [ALU_OP_W-1:0] PR2_alu_op,
  output logic [DATA_W-1:0]   PR2_imm,
  output logic [DATA_W-1:0]   PR2_rs_data,
  output logic [DATA_W-1:0]   PR2_rt_data,
  output logic [CNT_W-1:0]    stall_count
);

  // All PR2 fields in one record; the all-zero value is the bubble.
  typedef struct packed {
    logic                valid;
    logic                rf_write_en;
    logic                mem_read;
    logic                mem_write;
    logic                alu_src;
    logic [2:0]          rs;
    logic [2:0]          rt;
    logic [2:0]          rd;
    logic [ALU_OP_W-1:0] alu_op;
    logic [DATA_W-1:0]   imm;
    logic [DATA_W-1:0]   rs_data;
    logic [DATA_W-1:0]   rt_data;
  } pr2_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  pr2_t             pr2_q;
  pr2_t             id_in;
  logic [CNT_W-1:0] cnt_q;
  logic             rs_hit;
  logic             rt_hit;
  logic             load_use;

  assign id_in = '{
    valid:       ID_valid,
    rf_write_en: ID_RF_write_en,
    mem_read:    ID_MEM_read,
    mem_write:   ID_MEM_write,
    alu_src:     ID_alu_src,
    rs:          ID_rs,
    rt:          ID_rt,
    rd:          ID_rd,
    alu_op:      ID_alu_op,
    imm:         ID_imm,
    rs_data:     ID_rs_data,
    rt_data:     ID_rt_data
  };

  // Hazard detection: a real load in PR2 whose destination is read by ID.
  // Matches only count on operands the ID instruction actually reads.
  always_comb begin
    rs_hit   = ID_uses_rs & (pr2_q.rd == ID_rs);
    rt_hit   = ID_uses_rt & (pr2_q.rd == ID_rt);
    load_use = pr2_q.valid & pr2_q.mem_read & pr2_q.rf_write_en & ID_valid
             & (rs_hit | rt_hit);
  end

  // A flush kills the consumer anyway, so no stall is needed then; reset
  // also suppresses it so the front end is never held during reset.
  assign stall = load_use & ~flush & ~rst;

  // PR2 update in priority order: reset, flush, hold, load-use bubble, load.
  // Hold freezes PR2 even when load_use is true; the bubble goes in on the
  // first edge without hold if the hazard still exists then.
  always_ff @(posedge clk) begin
    if (rst) begin
      pr2_q <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      pr2_q <= '0;
    end else if (hold) begin
      pr2_q <= pr2_q;
    end else if (load_use) begin
      pr2_q <= '0;
      if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
    end else begin
      pr2_q <= id_in;
    end
  end

  assign PR2_valid       = pr2_q.valid;
  assign PR2_RF_write_en = pr2_q.rf_write_en;
  assign PR2_MEM_read    = pr2_q.mem_read;
  assign PR2_MEM_write   = pr2_q.mem_write;
  assign PR2_alu_src     = pr2_q.alu_src;
  assign PR2_rs          = pr2_q.rs;
  assign PR2_rt          = pr2_q.rt;
  assign PR2_rd          = pr2_q.rd;
  assign PR2_alu_op      = pr2_q.alu_op;
  assign PR2_imm         = pr2_q.imm;
  assign PR2_rs_data     = pr2_q.rs_data;
  assign PR2_rt_data     = pr2_q.rt_data;
  assign stall_count     = cnt_q;

endmodule

// File: tb/tb_pr2_id_ex_reg.sv
// Bench for pr2_id_ex_reg. Two instances share all inputs: one with the
// default 16-bit counter and one with a 2-bit counter to reach saturation.
module tb_pr2_id_ex_reg;

  localparam int VW = 65;

  // Clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, hold, flush;
  logic        ID_valid, ID_uses_rs, ID_uses_rt;
  logic        ID_RF_write_en, ID_MEM_read, ID_MEM_write, ID_alu_src;
  logic [2:0]  ID_rs, ID_rt, ID_rd, ID_alu_op;
  logic [15:0] ID_imm, ID_rs_data, ID_rt_data;

  logic        stall, s_stall;
  logic        PR2_valid, PR2_RF_write_en, PR2_MEM_read, PR2_MEM_write, PR2_alu_src;
  logic [2:0]  PR2_rs, PR2_rt, PR2_rd, PR2_alu_op;
  logic [15:0] PR2_imm, PR2_rs_data, PR2_rt_data, stall_count;
  logic        s_valid, s_we, s_mr, s_mw, s_as;
  logic [2:0]  s_rs, s_rt, s_rd, s_op;
  logic [15:0] s_imm, s_rsd, s_rtd;
  logic [1:0]  s_count;

  pr2_id_ex_reg dut (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush),
    .ID_valid(ID_valid), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_rd(ID_rd),
    .ID_uses_rs(ID_uses_rs), .ID_uses_rt(ID_uses_rt),
    .ID_RF_write_en(ID_RF_write_en), .ID_MEM_read(ID_MEM_read),
    .ID_MEM_write(ID_MEM_write), .ID_alu_src(ID_alu_src),
    .ID_alu_op(ID_alu_op), .ID_imm(ID_imm),
    .ID_rs_data(ID_rs_data), .ID_rt_data(ID_rt_data),
    .stall(stall), .PR2_valid(PR2_valid), .PR2_RF_write_en(PR2_RF_write_en),
    .PR2_MEM_read(PR2_MEM_read), .PR2_MEM_write(PR2_MEM_write),
    .PR2_alu_src(PR2_alu_src), .PR2_rs(PR2_rs), .PR2_rt(PR2_rt),
    .PR2_rd(PR2_rd), .PR2_alu_op(PR2_alu_op), .PR2_imm(PR2_imm),
    .PR2_rs_data(PR2_rs_data), .PR2_rt_data(PR2_rt_data),
    .stall_count(stall_count)
  );

  pr2_id_ex_reg #(.DATA_W(16), .ALU_OP_W(3), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush),
    .ID_valid(ID_valid), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_rd(ID_rd),
    .ID_uses_rs(ID_uses_rs), .ID_uses_rt(ID_uses_rt),
    .ID_RF_write_en(ID_RF_write_en), .ID_MEM_read(ID_MEM_read),
    .ID_MEM_write(ID_MEM_write), .ID_alu_src(ID_alu_src),
    .ID_alu_op(ID_alu_op), .ID_imm(ID_imm),
    .ID_rs_data(ID_rs_data), .ID_rt_data(ID_rt_data),
    .stall(s_stall), .PR2_valid(s_valid), .PR2_RF_write_en(s_we),
    .PR2_MEM_read(s_mr), .PR2_MEM_write(s_mw), .PR2_alu_src(s_as),
    .PR2_rs(s_rs), .PR2_rt(s_rt), .PR2_rd(s_rd), .PR2_alu_op(s_op),
    .PR2_imm(s_imm), .PR2_rs_data(s_rsd), .PR2_rt_data(s_rtd),
    .stall_count(s_count)
  );

  // Observed PR2 record, layout:
  // [64] valid [63] we [62] mem_read [61] mem_write [60] alu_src
  // [59:57] rs [56:54] rt [53:51] rd [50:48] op [47:32] imm [31:16] rs_data [15:0] rt_data
  logic [VW-1:0] obs_vec, s_obs_vec, id_vec;
  assign obs_vec = {PR2_valid, PR2_RF_write_en, PR2_MEM_read, PR2_MEM_write, PR2_alu_src,
                    PR2_rs, PR2_rt, PR2_rd, PR2_alu_op, PR2_imm, PR2_rs_data, PR2_rt_data};
  assign s_obs_vec = {s_valid, s_we, s_mr, s_mw, s_as, s_rs, s_rt, s_rd, s_op,
                      s_imm, s_rsd, s_rtd};
  assign id_vec = {ID_valid, ID_RF_write_en, ID_MEM_read, ID_MEM_write, ID_alu_src,
                   ID_rs, ID_rt, ID_rd, ID_alu_op, ID_imm, ID_rs_data, ID_rt_data};

  // Scoreboard: reference state plus expected-result queues
  logic [VW-1:0] m_vec;
  logic [15:0]   m_cnt;
  logic [1:0]    m_cnt2;
  logic [VW-1:0] exp_q[$];
  logic [15:0]   cnt_q[$];
  logic [1:0]    cnt2_q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic set_id(input logic v, input logic [2:0] rs, input logic [2:0] rt,
                        input logic [2:0] rd, input logic urs, input logic urt,
                        input logic we, input logic mr, input logic mw, input logic as,
                        input logic [2:0] op, input logic [15:0] imm,
                        input logic [15:0] rsd, input logic [15:0] rtd);
    ID_valid = v; ID_rs = rs; ID_rt = rt; ID_rd = rd;
    ID_uses_rs = urs; ID_uses_rt = urt;
    ID_RF_write_en = we; ID_MEM_read = mr; ID_MEM_write = mw; ID_alu_src = as;
    ID_alu_op = op; ID_imm = imm; ID_rs_data = rsd; ID_rt_data = rtd;
  endtask

  task automatic set_rand(input int max_reg);
    set_id(1'($urandom_range(0, 1)), 3'($urandom_range(0, max_reg)),
           3'($urandom_range(0, max_reg)), 3'($urandom_range(0, max_reg)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), 16'($urandom_range(0, 65535)),
           16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
  endtask

  // One clock cycle: check stall before the edge, push the expected next
  // state, then pop and compare after the edge.
  task automatic cycle(input logic r, input logic h, input logic f);
    logic          lu, exp_stall;
    logic [VW-1:0] e_vec;
    rst = r; hold = h; flush = f;
    #1;
    lu = m_vec[64] & m_vec[62] & m_vec[63] & ID_valid &
         ((ID_uses_rs & (m_vec[53:51] == ID_rs)) | (ID_uses_rt & (m_vec[53:51] == ID_rt)));
    exp_stall = lu & ~f & ~r;
    chk("stall", 80'(stall), 80'(exp_stall));
    chk("stall_sat_inst", 80'(s_stall), 80'(exp_stall));
    if (r) begin
      m_vec = '0; m_cnt = '0; m_cnt2 = '0;
    end else if (f) begin
      m_vec = '0;
    end else if (h) begin
      m_vec = m_vec;
    end else if (lu) begin
      m_vec = '0;
      if (m_cnt != 16'hffff) m_cnt = m_cnt + 16'd1;
      if (m_cnt2 != 2'd3) m_cnt2 = m_cnt2 + 2'd1;
    end else begin
      m_vec = id_vec;
    end
    exp_q.push_back(m_vec);
    cnt_q.push_back(m_cnt);
    cnt2_q.push_back(m_cnt2);
    @(posedge clk);
    #1;
    e_vec = exp_q.pop_front();
    chk("pr2_fields", 80'(obs_vec), 80'(e_vec));
    chk("pr2_fields_sat_inst", 80'(s_obs_vec), 80'(e_vec));
    chk("stall_count", 80'(stall_count), 80'(cnt_q.pop_front()));
    chk("stall_count_sat", 80'(s_count), 80'(cnt2_q.pop_front()));
  endtask

  // Directed stimulus sequence
  initial begin
    logic [1:0] want;
    m_vec = '0; m_cnt = '0; m_cnt2 = '0;
    rst = 1'b1; hold = 1'b0; flush = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    // Reset with live ID traffic
    set_rand(7); ID_valid = 1'b1;
    cycle(1, 0, 0);
    set_rand(7); ID_valid = 1'b1;
    cycle(1, 0, 0);
    chk("reset_valid", 80'(PR2_valid), 80'(0));
    chk("reset_count", 80'(stall_count), 80'(0));

    // Normal flow: ADD r3 = r1 + r2
    set_id(1, 3'd1, 3'd2, 3'd3, 1, 1, 1, 0, 0, 0, 3'd1, 16'h0, 16'h1234, 16'h0042);
    cycle(0, 0, 0);
    chk("add_rs", 80'(PR2_rs), 80'(1));
    chk("add_rt", 80'(PR2_rt), 80'(2));
    chk("add_rd", 80'(PR2_rd), 80'(3));
    chk("add_rs_data", 80'(PR2_rs_data), 80'(16'h1234));
    chk("add_valid", 80'(PR2_valid), 80'(1));

    // Load-use: LW r5 then consumer of r5
    set_id(1, 3'd2, 3'd0, 3'd5, 1, 0, 1, 1, 0, 1, 3'd0, 16'h4, 16'h100, 16'h0);
    cycle(0, 0, 0);
    set_id(1, 3'd5, 3'd6, 3'd7, 1, 1, 1, 0, 0, 0, 3'd2, 16'h0, 16'haaaa, 16'hbbbb);
    #1;
    chk("lu_stall_high", 80'(stall), 80'(1));
    cycle(0, 0, 0);
    chk("lu_bubble", 80'(PR2_valid), 80'(0));
    chk("lu_count", 80'(stall_count), 80'(1));
    chk("lu_stall_drops", 80'(stall), 80'(0));
    cycle(0, 0, 0);
    chk("lu_consumer_in", 80'(PR2_rs), 80'(5));

    // Unused operand match: no stall
    set_id(1, 3'd2, 3'd0, 3'd5, 1, 0, 1, 1, 0, 1, 3'd0, 16'h8, 16'h100, 16'h0);
    cycle(0, 0, 0);
    set_id(1, 3'd1, 3'd5, 3'd5, 1, 0, 1, 0, 0, 0, 3'd1, 16'h0, 16'h1, 16'h2);
    #1;
    chk("unused_rt_nostall", 80'(stall), 80'(0));
    cycle(0, 0, 0);
    // ADD r5 in PR2, consumer of r5: not a load
    set_id(1, 3'd5, 3'd1, 3'd4, 1, 1, 1, 0, 0, 0, 3'd1, 16'h0, 16'h3, 16'h4);
    #1;
    chk("nonload_nostall", 80'(stall), 80'(0));
    cycle(0, 0, 0);

    // Load without RF write, then invalid consumer
    set_id(1, 3'd2, 3'd0, 3'd6, 1, 0, 0, 1, 0, 1, 3'd0, 16'h0, 16'h0, 16'h0);
    cycle(0, 0, 0);
    set_id(1, 3'd6, 3'd6, 3'd1, 1, 1, 1, 0, 0, 0, 3'd1, 16'h0, 16'h5, 16'h6);
    cycle(0, 0, 0);
    set_id(1, 3'd2, 3'd0, 3'd6, 1, 0, 1, 1, 0, 1, 3'd0, 16'h0, 16'h0, 16'h0);
    cycle(0, 0, 0);
    set_id(0, 3'd6, 3'd6, 3'd1, 1, 1, 1, 0, 0, 0, 3'd1, 16'h0, 16'h5, 16'h6);
    cycle(0, 0, 0);

    // Load to r0 matching both operands: one stall, one increment
    set_id(1, 3'd1, 3'd0, 3'd0, 1, 0, 1, 1, 0, 1, 3'd0, 16'h0, 16'h0, 16'h0);
    cycle(0, 0, 0);
    set_id(1, 3'd0, 3'd0, 3'd2, 1, 1, 1, 0, 0, 0, 3'd1, 16'h0, 16'h7, 16'h7);
    cycle(0, 0, 0);
    chk("r0_count", 80'(stall_count), 80'(2));
    cycle(0, 0, 0);

    // Flush beats load-use, also with hold
    set_id(1, 3'd2, 3'd0, 3'd5, 1, 0, 1, 1, 0, 1, 3'd0, 16'h0, 16'h0, 16'h0);
    cycle(0, 0, 0);
    set_id(1, 3'd5, 3'd6, 3'd7, 1, 1, 1, 0, 0, 0, 3'd2, 16'h0, 16'h1, 16'h2);
    cycle(0, 0, 1);
    chk("flush_bubble", 80'(PR2_valid), 80'(0));
    chk("flush_count", 80'(stall_count), 80'(2));
    set_id(1, 3'd2, 3'd0, 3'd5, 1, 0, 1, 1, 0, 1, 3'd0, 16'h0, 16'h0, 16'h0);
    cycle(0, 0, 0);
    set_id(1, 3'd5, 3'd6, 3'd7, 1, 1, 1, 0, 0, 0, 3'd2, 16'h0, 16'h1, 16'h2);
    cycle(0, 1, 1);
    chk("flush_hold_bubble", 80'(PR2_valid), 80'(0));

    // Hold with a pending load-use: frozen 3 cycles, then bubble
    set_id(1, 3'd2, 3'd0, 3'd5, 1, 0, 1, 1, 0, 1, 3'd0, 16'h9, 16'h0, 16'h0);
    cycle(0, 0, 0);
    set_id(1, 3'd5, 3'd6, 3'd7, 1, 1, 1, 0, 0, 0, 3'd2, 16'h0, 16'h1, 16'h2);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0);
    chk("hold_frozen_rd", 80'(PR2_rd), 80'(5));
    chk("hold_count", 80'(stall_count), 80'(2));
    cycle(0, 0, 0);
    chk("after_hold_count", 80'(stall_count), 80'(3));
    cycle(0, 0, 0);

    // Reset mid-stall
    set_id(1, 3'd2, 3'd0, 3'd5, 1, 0, 1, 1, 0, 1, 3'd0, 16'h0, 16'h0, 16'h0);
    cycle(0, 0, 0);
    set_id(1, 3'd5, 3'd6, 3'd7, 1, 1, 1, 0, 0, 0, 3'd2, 16'h0, 16'h1, 16'h2);
    cycle(1, 0, 0);
    chk("rst_mid_stall", 80'(stall), 80'(0));

    // Saturation of the 2-bit counter: 1, 2, 3, 3, 3
    for (int i = 0; i < 5; i++) begin
      set_id(1, 3'd2, 3'd0, 3'd4, 1, 0, 1, 1, 0, 1, 3'd0, 16'h0, 16'h0, 16'h0);
      cycle(0, 0, 0);
      set_id(1, 3'd4, 3'd1, 3'd7, 1, 1, 1, 0, 0, 0, 3'd2, 16'h0, 16'h1, 16'h2);
      cycle(0, 0, 0);
      want = (i == 0) ? 2'd1 : (i == 1) ? 2'd2 : 2'd3;
      chk("sat_count", 80'(s_count), 80'(want));
    end

    // Random traffic over a small register range for frequent hazards
    for (int i = 0; i < 60; i++) begin
      set_rand(3);
      cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 7) == 0));
    end

    // Final report
    chk("queue_drained", 80'(exp_q.size()), 80'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
